mips_muldiv_unit: RTL

//  Multi-cycle MIPS multiply/divide unit that owns the HI/LO registers.

---
 rtl/mips_muldiv_if.sv | 34 +++
 rtl/mips_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/result bundle between EX and the multiply/divide unit.
// Optional macro MULDIV_DIVZERO_EN adds the divzero result flag.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
  logic             divzero;
`endif

  modport master (
    output start, op, op1, op2, flush,
`ifdef MULDIV_DIVZERO_EN
    input  divzero,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op1, op2, flush,
`ifdef MULDIV_DIVZERO_EN
    output divzero,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: multi-cycle MIPS multiply/divide unit owning HI/LO.
// Ops: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
// Multiply result appears MUL_LATENCY cycles after accept; divide is a
// restoring radix-2 loop on magnitudes (WIDTH cycles) plus one sign-fix cycle.
// Optional macro MULDIV_DIVZERO_EN adds a divide-by-zero flag that pulses
// together with done.
module mips_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_b,
  mips_muldiv_if.slave md
);

  localparam int CNT_W = $clog2((WIDTH > 8) ? WIDTH : 8) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
  logic             divzero;
`endif

  // operands and divider working registers (no reset needed, written at accept)
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_signed;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             op1_neg;
  logic             op2_neg;

  // Full 2*WIDTH product; sign-extending both factors makes a plain multiply
  // correct for signed operands.
  function automatic logic [2*WIDTH-1:0] mul_product(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sgn
  );
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] ye;
    logic signed [2*WIDTH-1:0] p;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    p  = xe * ye;
    return p;
  endfunction

  // Two's-complement negate when requested; -2^(WIDTH-1) maps to itself,
  // which gives the architected overflow result for free.
  function automatic logic [WIDTH-1:0] apply_sign(
    input logic [WIDTH-1:0] mag,
    input logic             neg
  );
    return neg ? -mag : mag;
  endfunction

  // One restoring-division step: shift next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    diff     = trial - {1'b0, dvsr};
    fits     = (trial >= {1'b0, dvsr});
    rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
    op1_neg  = (md.op == 3'd2) && md.op1[WIDTH-1];
    op2_neg  = (md.op == 3'd2) && md.op2[WIDTH-1];
  end

  // Control FSM with registered busy/done and the HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULDIV_DIVZERO_EN
      divzero <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      divzero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (md.start && !md.flush) begin
            case (md.op)
              3'd0, 3'd1: begin
                mul_a      <= md.op1;
                mul_b      <= md.op2;
                mul_signed <= (md.op == 3'd0);
                cnt        <= CNT_W'(MUL_LATENCY - 1);
                state      <= MUL;
                busy       <= 1'b1;
              end
              3'd2, 3'd3: begin
                if (md.op2 != '0) begin
                  rem   <= '0;
                  quo   <= apply_sign(md.op1, op1_neg);
                  dvsr  <= apply_sign(md.op2, op2_neg);
                  neg_q <= op1_neg ^ op2_neg;
                  neg_r <= op1_neg;
                  cnt   <= CNT_W'(WIDTH - 1);
                  state <= DIV;
                  busy  <= 1'b1;
                end else begin
                  hi      <= md.op1;
                  lo      <= '1;
                  done    <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                  divzero <= 1'b1;
`endif
                end
              end
              3'd4: begin
                hi   <= md.op1;
                done <= 1'b1;
              end
              3'd5: begin
                lo   <= md.op1;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (md.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= mul_product(mul_a, mul_b, mul_signed);
            done     <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          if (md.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!md.flush) begin
            lo   <= apply_sign(quo, neg_q);
            hi   <= apply_sign(rem, neg_r);
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = busy;
  assign md.done = done;
  assign md.hi   = hi;
  assign md.lo   = lo;
`ifdef MULDIV_DIVZERO_EN
  assign md.divzero = divzero;
`endif

endmodule
